// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, idle-high line, fed by a DEPTH-entry byte FIFO.
// Queued bytes are sent back to back with no idle gap between frames.
module uart_tx #(
    parameter int unsigned DELAY_FRAMES = 234,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             txData,
    input  logic                   txValid,
    output logic                   txReady,
    output logic                   uartTx,
    output logic                   txBusy,
    output logic [$clog2(DEPTH):0] fifoCount
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(DELAY_FRAMES);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            uart_q, uart_d;
    logic            busy_q, busy_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [DEPTH];

    logic push;
    logic pop;
    logic timer_end;
    logic fifo_nempty;

    assign txReady     = (count_q != CW'(DEPTH));
    assign push        = txValid & txReady;
    assign fifo_nempty = (count_q != '0);
    assign timer_end   = (timer_q == TW'(DELAY_FRAMES - 1));

    // Frame sequencer; the FIFO head is popped only when a new frame starts.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        uart_d    = uart_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                uart_d = 1'b1;
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    uart_d  = 1'b0;
                    timer_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (timer_end) begin
                    timer_d   = '0;
                    uart_d    = shift_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (timer_end) begin
                    timer_d = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        uart_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        uart_d    = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (timer_end) begin
                    timer_d = '0;
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        uart_d  = 1'b0;
                        state_d = START;
                    end else begin
                        uart_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        busy_d = (state_d != IDLE) | (count_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            uart_q    <= 1'b1;
            busy_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            uart_q    <= uart_d;
            busy_q    <= busy_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= txData;
        end
    end

    assign uartTx    = uart_q;
    assign txBusy    = busy_q;
    assign fifoCount = count_q;
endmodule
